// File: rtl/display_scan.sv
// display_scan: 4-digit multiplexed 7-segment driver for an mm.ss stopwatch.
// Scans one digit per REFRESH_DIV cycles. In adjust mode the selected field
// blinks with a half-period of BLINK_DIV cycles. Every output is registered.
module display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic       adjust,
    input  logic       select,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0] refresh_cnt;
    logic [1:0]    index;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    logic          refresh_wrap;
    logic          blink_wrap;
    logic [3:0]    digit;
    logic          blank;

    // BCD to active-low {g,f,e,d,c,b,a}; non-decimal values show nothing
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));
    assign blink_wrap   = (blink_cnt == BW'(BLINK_DIV - 1));

    // Digit mux and blanking decision from the current scan position
    always_comb begin
        digit = sec0;
        case (index)
            2'd0: digit = sec0;
            2'd1: digit = sec1;
            2'd2: digit = min0;
            2'd3: digit = min1;
            default: digit = sec0;
        endcase
        // select=0 blinks minutes (indices 2,3), select=1 blinks seconds (0,1)
        blank = adjust && phase && (select ? ~index[1] : index[1]);
    end

    // Refresh counter and scan index; independent of adjust/select
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            index       <= 2'd0;
        end else if (refresh_wrap) begin
            refresh_cnt <= '0;
            index       <= index + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // Blink timer runs only in adjust mode; leaving adjust rearms a visible half-period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!adjust) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Registered display outputs; the decimal point marks mm.ss and ignores blanking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            dp <= (index != 2'd2);
            if (blank) begin
                an  <= 4'b1111;
                seg <= 7'h7F;
            end else begin
                an  <= ~(4'b0001 << index);
                seg <= decode(digit);
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: directed scan/reset cases plus random digit,
// adjust and select traffic against a time-based reference model.
module tb_display_scan;

    localparam int RD = 4;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] min1, min0, sec1, sec0;
    logic       adjust, select;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: edges since reset release, consecutive adjust=1 edges
    int t_edges;
    int adj_edges;

    logic [6:0] seg_tbl [16];

    display_scan #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset),
        .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
        .adjust(adjust), .select(select),
        .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // one clock edge: predict from pre-edge inputs and elapsed time, then compare
    task automatic step(input string tag);
        int pos, ph;
        logic [3:0] d, e_an;
        logic [6:0] e_seg;
        logic e_dp, blk;
        @(posedge clk);
        pos = (t_edges / RD) % 4;
        ph  = (adj_edges / BD) % 2;
        d   = (pos == 0) ? sec0 : (pos == 1) ? sec1 : (pos == 2) ? min0 : min1;
        blk = adjust && (ph == 1) && (select ? (pos < 2) : (pos >= 2));
        e_an  = blk ? 4'b1111 : ~(4'b0001 << pos);
        e_seg = blk ? 7'h7F : seg_tbl[d];
        e_dp  = (pos == 2) ? 1'b0 : 1'b1;
        t_edges++;
        adj_edges = adjust ? adj_edges + 1 : 0;
        #1;
        chk({tag, "_an"}, 16'(an), 16'(e_an));
        chk({tag, "_seg"}, 16'(seg), 16'(e_seg));
        chk({tag, "_dp"}, 16'(dp), 16'(e_dp));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_an"}, 16'(an), 16'hF);
        chk({tag, "_seg"}, 16'(seg), 16'h7F);
        chk({tag, "_dp"}, 16'(dp), 16'h1);
    endtask

    initial begin
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        reset = 1'b1;
        {min1, min0, sec1, sec0} = {4'd1, 4'd2, 4'd3, 4'd4};
        adjust = 1'b0;
        select = 1'b0;
        t_edges = 0;
        adj_edges = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        reset = 1'b0;

        // plain scan of 1,2,3,4 over two full rotations
        for (int i = 0; i < 32; i++) step("scan");

        // non-decimal sec0 blanks only that digit's segments
        sec0 = 4'hC;
        for (int i = 0; i < 16; i++) step("hexdig");
        sec0 = 4'd5;

        // async reset between edges, mid-scan
        repeat (6) step("pre_rst");
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_rst");
        #1;
        reset = 1'b0;
        t_edges = 0;
        adj_edges = 0;
        step("post_rst");

        // blinking minutes from a clean start
        adjust = 1'b1;
        select = 1'b0;
        for (int i = 0; i < 40; i++) step("blink_min");
        // drop adjust while blanked, then re-enter with seconds selected
        while (((adj_edges / BD) % 2) == 0) step("to_blank");
        adjust = 1'b0;
        step("adj_drop");
        adjust = 1'b1;
        select = 1'b1;
        for (int i = 0; i < 30; i++) step("blink_sec");
        select = 1'b0;
        for (int i = 0; i < 10; i++) step("sel_swap");

        // random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                min1 = 4'($urandom_range(0, 15));
                min0 = 4'($urandom_range(0, 15));
                sec1 = 4'($urandom_range(0, 15));
                sec0 = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 39) == 0) adjust = ~adjust;
            if ($urandom_range(0, 15) == 0) select = ~select;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // absolute watchdog so the run always ends
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
